// File: rtl/uart_rx_pkg.sv
// Shared UART receive-path definitions: default widths/depths, the FIFO
// occupancy state classification used for debug and coverage, and a small
// helper used by the FIFO's depth check at elaboration.
package uart_rx_pkg;

  localparam int UART_DATA_WIDTH       = 8;
  localparam int RX_FIFO_DEPTH_DEFAULT = 16;

  // Occupancy class of the receive FIFO; derived purely from its level.
  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } rx_fifo_state_e;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Register-array storage for the receive FIFO: one synchronous write port,
// one asynchronous read port. Contents are deliberately left unreset.
module uart_rx_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]    wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]    rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Store the incoming byte at the write address.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures strobed bytes into a power-of-two circular
// buffer and presents them first-word-fall-through over valid/ready.
// Pointers carry an extra wrap bit so full and empty are distinguishable
// without a separate counter. Overruns are sticky until cleared.
// Optional: define UART_RX_FIFO_OVERRUN_CNT_EN to add overrun_cnt_o, a
// saturating count of dropped bytes.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = RX_FIFO_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      wr_data_i,
  input  logic                       wr_valid_i,
  input  logic                       flush_i,
  input  logic                       clr_overrun_i,
  output logic [DATA_WIDTH-1:0]      rd_data_o,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
`ifdef UART_RX_FIFO_OVERRUN_CNT_EN
  output logic [7:0]                 overrun_cnt_o,
`endif
  output logic                       overrun_o
);

  localparam int ADDR_W = $clog2(DEPTH);

  if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
  logic                  overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  empty, full;
  logic                  rd_fire, wr_fire, drop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  // A flush swallows any same-cycle write, so it can neither store nor drop.
  assign rd_fire = !empty && rd_ready_i;
  assign wr_fire = wr_valid_i && (!full || rd_fire) && !flush_i;
  assign drop    = wr_valid_i && full && !rd_fire && !flush_i;

  uart_rx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_fire),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i (wr_data_i),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (mem_rd_data)
  );

  // Next pointer and sticky-flag values.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (clr_overrun_i) overrun_d = 1'b0;
    if (drop)          overrun_d = 1'b1;
  end

  // Pointer/flag registers; hold_q remembers the last presented byte so the
  // output never shows unwritten storage while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
      hold_q    <= rd_data_o;
    end
  end

`ifdef UART_RX_FIFO_OVERRUN_CNT_EN
  logic [7:0] ocnt_q, ocnt_d;

  // Saturating drop counter; a drop coinciding with a clear restarts at 1.
  always_comb begin
    ocnt_d = ocnt_q;
    if (clr_overrun_i) ocnt_d = 8'd0;
    if (drop) begin
      if (clr_overrun_i)        ocnt_d = 8'd1;
      else if (ocnt_q != 8'hFF) ocnt_d = ocnt_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ocnt_q <= 8'd0;
    else        ocnt_q <= ocnt_d;
  end

  assign overrun_cnt_o = ocnt_q;
`endif

  assign rd_data_o  = empty ? hold_q : mem_rd_data;
  assign rd_valid_o = !empty;
  assign level_o    = wr_ptr_q - rd_ptr_q;
  assign full_o     = full;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus randomized traffic. A
// reference model at each clock edge decides acceptance from the FIFO rules
// and records expected bytes; a monitor at the falling edge checks the DUT's
// outputs and consumes expected bytes as the DUT hands them out.
module tb_uart_rx_fifo;
  import uart_rx_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int SBW   = 8192;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          flush = 1'b0;
  logic          clr_ov = 1'b0;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [4:0]    level;
  logic          full;
  logic          overrun;
  logic [7:0]    ocnt;

  int vecs = 0;
  int errs = 0;

  // reference model state (written only by the model process)
  logic [DW-1:0] exp_mem [SBW];
  int wr_idx = 0;
  int base_idx = 0;
  int exp_level = 0;
  bit exp_ov = 0;
  int exp_cnt = 0;

  // monitor state
  int rd_idx = 0;
  logic [DW-1:0] last_shown = '0;
  int seen_state [3] = '{0, 0, 0};

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_data_i     (wr_data),
    .wr_valid_i    (wr_valid),
    .flush_i       (flush),
    .clr_overrun_i (clr_ov),
    .rd_data_o     (rd_data),
    .rd_valid_o    (rd_valid),
    .rd_ready_i    (rd_ready),
    .level_o       (level),
    .full_o        (full),
`ifdef UART_RX_FIFO_OVERRUN_CNT_EN
    .overrun_cnt_o (ocnt),
`endif
    .overrun_o     (overrun)
  );

`ifndef UART_RX_FIFO_OVERRUN_CNT_EN
  assign ocnt = 8'd0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the FIFO as a bounded queue of accepted bytes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_idx  = wr_idx;
      exp_level = 0;
      exp_ov    = 0;
      exp_cnt   = 0;
    end else begin
      bit rd_f;
      bit dropped;
      dropped = 0;
      if (flush) begin
        base_idx  = wr_idx;
        exp_level = 0;
      end else begin
        rd_f = (exp_level > 0) && rd_ready;
        if (wr_valid) begin
          if (exp_level < DEPTH || rd_f) begin
            exp_mem[wr_idx % SBW] = wr_data;
            wr_idx++;
            exp_level++;
          end else begin
            dropped = 1;
          end
        end
        if (rd_f) exp_level--;
      end
      if (clr_ov) begin
        exp_ov  = 0;
        exp_cnt = 0;
      end
      if (dropped) begin
        exp_ov  = 1;
        exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      end
    end
  end

  // Monitor: check outputs mid-cycle and consume bytes the DUT hands out.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_shown = '0;
    end else begin
      if (rd_idx < base_idx) rd_idx = base_idx;
      chk("level", {27'd0, level}, exp_level);
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, exp_level != 0});
      chk("full", {31'd0, full}, {31'd0, exp_level == DEPTH});
      chk("overrun", {31'd0, overrun}, {31'd0, exp_ov});
`ifdef UART_RX_FIFO_OVERRUN_CNT_EN
      chk("overrun_cnt", {24'd0, ocnt}, exp_cnt);
`endif
      if (rd_valid) begin
        if (rd_idx < wr_idx) begin
          chk("head_data", {24'd0, rd_data}, {24'd0, exp_mem[rd_idx % SBW]});
          last_shown = exp_mem[rd_idx % SBW];
          if (rd_ready && !flush) rd_idx++;
        end else begin
          vecs++;
          errs++;
          $display("FAIL pop at %0t: DUT valid with data %0h, expected no data", $time, rd_data);
        end
      end else begin
        chk("hold_data", {24'd0, rd_data}, {24'd0, last_shown});
      end
      if (exp_level == 0)          seen_state[FIFO_EMPTY]++;
      else if (exp_level == DEPTH) seen_state[FIFO_FULL]++;
      else                         seen_state[FIFO_PARTIAL]++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(first + i);
      step();
    end
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rd_ready = 1'b1;
    while (rd_valid && n < 64) begin
      step();
      n++;
    end
    rd_ready = 1'b0;
    chk("drain_empty", {31'd0, rd_valid}, 32'd0);
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    chk({tag, "_level"}, {27'd0, level}, 32'd0);
    chk({tag, "_full"}, {31'd0, full}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    chk({tag, "_rd_data"}, {24'd0, rd_data}, 32'd0);
    chk({tag, "_ocnt"}, {24'd0, ocnt}, 32'd0);
  endtask

  initial begin
    #2;
    chk_reset_outputs("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    // single byte, one-cycle latency, then consume
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    step();
    wr_valid = 1'b0;
    step();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    step();

    // fill to full, overrun with 0xEE, drain, clear overrun
    fill(16, 0);
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    step();
    wr_valid = 1'b0;
    step();
    drain();
    clr_ov = 1'b1;
    step();
    clr_ov = 1'b0;
    step();

    // full with simultaneous read and write of 0x77
    fill(16, 8'h10);
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    rd_ready = 1'b1;
    step();
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    step();
    drain();

    // streaming across the wrap point twice
    begin
      int sent;
      sent = 0;
      for (int c = 0; c < 400 && (sent < 40 || rd_valid); c++) begin
        wr_valid = (c % 3 == 0) && (sent < 40);
        wr_data  = DW'(sent);
        rd_ready = c[0];
        step();
        if (wr_valid) sent++;
      end
      wr_valid = 1'b0;
      chk("stream_sent", sent, 32'd40);
      drain();
    end

    // flush with a same-cycle write
    fill(5, 8'h30);
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    flush    = 1'b1;
    step();
    wr_valid = 1'b0;
    flush    = 1'b0;
    step();

    // asynchronous reset mid-stream with overrun set
    fill(17, 8'h40);
    wr_valid = 1'b1;
    wr_data  = 8'h99;
    rd_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // randomized traffic in low/medium/high drain-rate phases
    for (int p = 0; p < 12; p++) begin
      int rd_pct;
      rd_pct = (p % 3 == 0) ? 10 : ((p % 3 == 1) ? 50 : 90);
      for (int c = 0; c < 120; c++) begin
        wr_valid = ($urandom_range(99) < 60);
        wr_data  = DW'($urandom);
        rd_ready = ($urandom_range(99) < rd_pct);
        flush    = ($urandom_range(99) == 0);
        clr_ov   = ($urandom_range(39) == 0);
        step();
      end
    end
    wr_valid = 1'b0;
    flush    = 1'b0;
    clr_ov   = 1'b0;
    drain();

    chk("cov_empty_seen", {31'd0, seen_state[FIFO_EMPTY] > 0}, 32'd1);
    chk("cov_partial_seen", {31'd0, seen_state[FIFO_PARTIAL] > 0}, 32'd1);
    chk("cov_full_seen", {31'd0, seen_state[FIFO_FULL] > 0}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer placed directly downstream of the UART receiver.
- Captures each validated byte on a one-cycle write strobe and stores it in a power-of-two circular FIFO.
- Presents bytes to the consumer (bus bridge or command parser) over a first-word-fall-through valid/ready interface.
- Decouples bursty line arrival from consumer stalls and flags overruns.

Parameters:
- DATA_WIDTH, 8: byte width; matches the receiver's data word.
- DEPTH, 16: FIFO entries. Power of two, ≥2; enforced by elaboration assertion.
- ADDR_W, $clog2(DEPTH): derived, localparam only.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- wr_data_i, input, DATA_WIDTH: byte from receiver.
- wr_valid_i, input, 1: single-cycle strobe; wr_data_i is valid in that cycle.
- flush_i, input, 1: synchronous flush; empties the FIFO.
- clr_overrun_i, input, 1: synchronous clear of the sticky overrun flag.
- rd_data_o, output, DATA_WIDTH: head entry; valid when rd_valid_o=1.
- rd_valid_o, output, 1: FIFO non-empty.
- rd_ready_i, input, 1: consumer accepts head this cycle.
- level_o, output, ADDR_W+1: current occupancy, 0..DEPTH.
- full_o, output, 1: level_o == DEPTH.
- overrun_o, output, 1: sticky; a byte was dropped.

Behaviour:
- Reset (async, rst_n=0): wr_ptr=0, rd_ptr=0, level_o=0, rd_valid_o=0, full_o=0, overrun_o=0, rd_data_o=0.
- Storage contents are not reset.
- Pointers are ADDR_W+1 bits wide; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (addresses equal) && (wrap bits differ).
  - level_o = wr_ptr − rd_ptr, modulo 2^(ADDR_W+1).
- Read fire = rd_valid_o && rd_ready_i.
  - rd_ptr increments on the next edge.
  - rd_ready_i while empty has no effect.
- Write fire = wr_valid_i && (!full || read fire).
  - mem[wr_ptr[ADDR_W-1:0]] <= wr_data_i; wr_ptr increments.
  - Simultaneous read and write while full: both accepted, level unchanged.
- Write while full with no read fire:
  - Byte dropped; pointers and storage unchanged.
  - overrun_o <= 1 on the next edge.
- Write to empty FIFO: no bypass.
  - rd_valid_o rises on the edge after the write; latency = 1 cycle.
  - rd_data_o then shows that byte.
- FWFT read path:
  - rd_data_o = mem[rd_ptr addr], combinational from storage.
  - When empty, rd_data_o is held at its last value. X is not allowed.
- Wrap-around: pointers roll over naturally. Sustained traffic across 2×DEPTH entries preserves order with no loss.
- flush_i:
  - rd_ptr <= wr_ptr; level 0 on the next edge.
  - Same-cycle write is discarded; same-cycle read has no side effect.
  - overrun_o is untouched.
- clr_overrun_i:
  - overrun_o <= 0.
  - A same-cycle overrun event wins; the flag stays 1.
- Reset mid-operation: all state returns to reset values immediately (async). Queued data is lost.
- State summary (derived from level, no explicit FSM): EMPTY, PARTIAL, FULL.
  - EMPTY→PARTIAL on write without read.
  - PARTIAL→FULL when level reaches DEPTH.
  - FULL→PARTIAL on read fire without write.
  - PARTIAL→EMPTY when the last entry is read, or on flush.

Optional Feature:
- Macro: UART_RX_FIFO_OVERRUN_CNT_EN.
- Defined:
  - Adds output overrun_cnt_o [7:0].
  - Increments once per dropped byte and saturates at 255.
  - Cleared by clr_overrun_i; a same-cycle drop makes it 1.
  - Reset value 0.
- Undefined: port absent, no counter logic. All other behaviour is identical.

Decomposition:
- uart_rx_pkg (shared, extend the existing package):
  - UART_DATA_WIDTH = 8 and RX_FIFO_DEPTH_DEFAULT = 16.
  - typedef rx_fifo_state_e {FIFO_EMPTY, FIFO_PARTIAL, FIFO_FULL}, for bench coverage and debug.
- Sub-module uart_rx_fifo_mem:
  - DEPTH×DATA_WIDTH register array.
  - One synchronous write port, one asynchronous read port, no reset.
  - Top level holds pointers, flags, flush, overrun and the optional counter.

Test Plan:
- Reset, then write 0xA5 once → next cycle rd_valid_o=1, rd_data_o=0xA5, level_o=1. Assert rd_ready_i → level_o=0, rd_valid_o=0.
- Write 16 bytes 0x00..0x0F with rd_ready_i=0 → full_o=1, level_o=16. Drain → bytes read in order 0x00..0x0F.
- With FIFO full, write 0xEE with no read → dropped, overrun_o=1, level_o=16. Drain yields 0x00..0x0F only. Pulse clr_overrun_i → overrun_o=0 (with macro: overrun_cnt_o 1→0).
- With FIFO full, write 0x77 with rd_ready_i=1 in the same cycle → both fire, level_o stays 16, overrun_o=0. 0x77 appears as the 16th subsequent read.
- Stream 40 bytes (0x00..0x27) with rd_ready_i toggling 1-of-2 cycles, one write every 3 cycles (wrap crossed twice) → all 40 received in order, no overrun.
- Fill to level 5, assert flush_i together with wr_valid_i (0x55) → next cycle level_o=0, rd_valid_o=0. Then assert rst_n=0 asynchronously mid-stream → all outputs return to 0 without a clock edge.
